// File: rtl/control_pkg.sv
// Shared types and encodings for the registered instruction controller.
package control_pkg;

  typedef enum logic [1:0] {
    TypeR = 2'b00,
    TypeM = 2'b01,
    TypeB = 2'b10,
    TypeS = 2'b11
  } instruction_type_e;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StMemWait,
    StHalted
  } state_t;

  // R-class func codes
  localparam logic [3:0] FuncAnd  = 4'd0;
  localparam logic [3:0] FuncOr   = 4'd1;
  localparam logic [3:0] FuncXor  = 4'd2;
  localparam logic [3:0] FuncAdd  = 4'd3;
  localparam logic [3:0] FuncSub  = 4'd4;
  localparam logic [3:0] FuncSlt  = 4'd5;
  localparam logic [3:0] FuncSlte = 4'd6;
  localparam logic [3:0] FuncEq   = 4'd7;

  // M-class op3 codes
  localparam logic [2:0] MopStore = 3'b000;
  localparam logic [2:0] MopLoad  = 3'b001;
  localparam logic [2:0] MopHalt  = 3'b111;

  // B-class conditions
  localparam logic [1:0] BcEq  = 2'b00;
  localparam logic [1:0] BcLt  = 2'b01;
  localparam logic [1:0] BcLte = 2'b10;
  localparam logic [1:0] BcUn  = 2'b11;

  // S-class sub-ops
  localparam logic [1:0] ScLsl = 2'b00;
  localparam logic [1:0] ScLsr = 2'b01;
  localparam logic [1:0] ScBf  = 2'b10;
  localparam logic [1:0] ScBb  = 2'b11;

endpackage

// File: rtl/instr_decode.sv
// Pure field decode: instruction plus registered flags -> next control values.
module instr_decode #(
  parameter int unsigned INSTR_W = 9,
  parameter int unsigned LUT_W   = 5,
  parameter int unsigned SHAMT_W = 3
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic               flag_eq,
  input  logic               flag_lt,
  output logic               reg_write,
  output logic               mem_write,
  output logic               mem_read,
  output logic               halt,
  output logic               load_flags,
  output logic               branch,
  output logic [LUT_W-1:0]   lut_index,
  output logic [2:0]         aluop,
  output logic               shift_dir,
  output logic [SHAMT_W-1:0] shift_amt
);
  import control_pkg::*;

  instruction_type_e typ;
  logic [2:0]        op3;
  logic [1:0]        op2;
  logic [3:0]        func;

  assign typ  = instruction_type_e'(instr[INSTR_W-1 -: 2]);
  assign op3  = instr[INSTR_W-3 -: 3];
  assign op2  = op3[2:1];
  assign func = instr[3:0];

  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    halt       = 1'b0;
    load_flags = 1'b0;
    branch     = 1'b0;
    lut_index  = '0;
    aluop      = '0;
    shift_dir  = 1'b0;
    shift_amt  = '0;
    unique case (typ)
      TypeR: begin
        aluop = op3;
        if (func <= FuncSub) begin
          reg_write = 1'b1;
        end else if (func <= FuncEq) begin
          load_flags = 1'b1;
        end
      end
      TypeM: begin
        case (op3)
          MopStore: mem_write = 1'b1;
          MopLoad:  mem_read  = 1'b1;
          MopHalt:  halt      = 1'b1;
          default:  ;
        endcase
      end
      TypeB: begin
        lut_index = instr[LUT_W-1:0];
        case (op2)
          BcEq:    branch = flag_eq;
          BcLt:    branch = flag_lt;
          BcLte:   branch = flag_lt | flag_eq;
          default: branch = 1'b1;
        endcase
      end
      TypeS: begin
        case (op2)
          ScLsl, ScLsr: begin
            shift_dir = (op2 == ScLsr);
            shift_amt = instr[SHAMT_W-1:0];
            reg_write = 1'b1;
          end
          ScBf:    branch = flag_eq;
          default: branch = flag_lt;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Registered, handshaked instruction controller: decode, compare flags,
// memory request sequencing with timeout, and HALT parking.
module control_fsm #(
  parameter int unsigned INSTR_W     = 9,
  parameter int unsigned LUT_W       = 5,
  parameter int unsigned SHAMT_W     = 3,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               equal,
  input  logic               lessThan,
  input  logic               mem_ack,
  input  logic               start,
  output logic               regWrite,
  output logic               memWrite,
  output logic               memRead,
  output logic               branchEnable,
  output logic               mem_req,
  output logic [LUT_W-1:0]   LUTIndex,
  output logic [2:0]         Aluop,
  output logic               shiftDirection,
  output logic [SHAMT_W-1:0] shiftAmount,
  output logic               done,
  output logic               error
);
  import control_pkg::*;

  localparam bit          TimeoutEn = (MEM_TIMEOUT != 0);
  localparam int unsigned CntW      = TimeoutEn ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLimit = CntW'(MEM_TIMEOUT);

  state_t state_q, state_d;
  logic   flag_eq_q, flag_eq_d, flag_lt_q, flag_lt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic   reg_write_q, reg_write_d, mem_write_q, mem_write_d, mem_read_q, mem_read_d;
  logic   branch_q, branch_d, mem_req_q, mem_req_d, done_q, done_d, error_q, error_d;
  logic   shift_dir_q, shift_dir_d;
  logic [LUT_W-1:0]   lut_q, lut_d;
  logic [2:0]         aluop_q, aluop_d;
  logic [SHAMT_W-1:0] shift_amt_q, shift_amt_d;

  logic dec_reg_write, dec_mem_write, dec_mem_read, dec_halt, dec_load_flags, dec_branch;
  logic dec_shift_dir;
  logic [LUT_W-1:0]   dec_lut;
  logic [2:0]         dec_aluop;
  logic [SHAMT_W-1:0] dec_shift_amt;
  logic               accept;

  instr_decode #(
    .INSTR_W (INSTR_W),
    .LUT_W   (LUT_W),
    .SHAMT_W (SHAMT_W)
  ) u_decode (
    .instr      (instr),
    .flag_eq    (flag_eq_q),
    .flag_lt    (flag_lt_q),
    .reg_write  (dec_reg_write),
    .mem_write  (dec_mem_write),
    .mem_read   (dec_mem_read),
    .halt       (dec_halt),
    .load_flags (dec_load_flags),
    .branch     (dec_branch),
    .lut_index  (dec_lut),
    .aluop      (dec_aluop),
    .shift_dir  (dec_shift_dir),
    .shift_amt  (dec_shift_amt)
  );

  assign instr_ready = (state_q == StExec);
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    state_d     = state_q;
    flag_eq_d   = flag_eq_q;
    flag_lt_d   = flag_lt_q;
    cnt_d       = cnt_q;
    // Single-cycle pulses fall back to zero unless re-armed below
    reg_write_d = 1'b0;
    branch_d    = 1'b0;
    lut_d       = '0;
    aluop_d     = '0;
    shift_dir_d = 1'b0;
    shift_amt_d = '0;
    mem_write_d = mem_write_q;
    mem_read_d  = mem_read_q;
    mem_req_d   = mem_req_q;
    done_d      = done_q;
    error_d     = error_q;
    unique case (state_q)
      StIdle: state_d = StExec;
      StExec: begin
        if (accept) begin
          reg_write_d = dec_reg_write;
          branch_d    = dec_branch;
          lut_d       = dec_lut;
          aluop_d     = dec_aluop;
          shift_dir_d = dec_shift_dir;
          shift_amt_d = dec_shift_amt;
          if (dec_load_flags) begin
            flag_eq_d = equal;
            flag_lt_d = lessThan;
          end
          if (dec_mem_read || dec_mem_write) begin
            state_d     = StMemWait;
            mem_req_d   = 1'b1;
            mem_read_d  = dec_mem_read;
            mem_write_d = dec_mem_write;
            cnt_d       = CntW'(1);
          end else if (dec_halt) begin
            state_d = StHalted;
            done_d  = 1'b1;
          end
        end
      end
      StMemWait: begin
        if (mem_ack) begin
          state_d     = StExec;
          reg_write_d = mem_read_q;
          mem_req_d   = 1'b0;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          cnt_d       = '0;
        end else if (TimeoutEn && (cnt_q == CntLimit)) begin
          state_d     = StHalted;
          error_d     = 1'b1;
          done_d      = 1'b1;
          mem_req_d   = 1'b0;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          cnt_d       = '0;
        end else if (TimeoutEn) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHalted: begin
        if (start) begin
          state_d = StExec;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      flag_eq_q   <= 1'b0;
      flag_lt_q   <= 1'b0;
      cnt_q       <= '0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      branch_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      lut_q       <= '0;
      aluop_q     <= '0;
      shift_dir_q <= 1'b0;
      shift_amt_q <= '0;
    end else begin
      state_q     <= state_d;
      flag_eq_q   <= flag_eq_d;
      flag_lt_q   <= flag_lt_d;
      cnt_q       <= cnt_d;
      reg_write_q <= reg_write_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
      branch_q    <= branch_d;
      mem_req_q   <= mem_req_d;
      done_q      <= done_d;
      error_q     <= error_d;
      lut_q       <= lut_d;
      aluop_q     <= aluop_d;
      shift_dir_q <= shift_dir_d;
      shift_amt_q <= shift_amt_d;
    end
  end

  assign regWrite       = reg_write_q;
  assign memWrite       = mem_write_q;
  assign memRead        = mem_read_q;
  assign branchEnable   = branch_q;
  assign mem_req        = mem_req_q;
  assign LUTIndex       = lut_q;
  assign Aluop          = aluop_q;
  assign shiftDirection = shift_dir_q;
  assign shiftAmount    = shift_amt_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: vector table through a scoreboard, plus hand-written
// memory, timeout, halt and reset sequences.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] instr;
  logic       instr_valid, instr_ready, equal, lessThan, mem_ack, start;
  logic       regWrite, memWrite, memRead, branchEnable, mem_req, shiftDirection, done, error;
  logic [4:0] LUTIndex;
  logic [2:0] Aluop, shiftAmount;

  control_fsm #(
    .INSTR_W     (9),
    .LUT_W       (5),
    .SHAMT_W     (3),
    .MEM_TIMEOUT (15)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .equal          (equal),
    .lessThan       (lessThan),
    .mem_ack        (mem_ack),
    .start          (start),
    .regWrite       (regWrite),
    .memWrite       (memWrite),
    .memRead        (memRead),
    .branchEnable   (branchEnable),
    .mem_req        (mem_req),
    .LUTIndex       (LUTIndex),
    .Aluop          (Aluop),
    .shiftDirection (shiftDirection),
    .shiftAmount    (shiftAmount),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] instr;
    logic       valid, eq, lt;
    logic       rw, br;
    logic [4:0] lut;
    logic [2:0] alu;
    logic       sd;
    logic [2:0] sa;
  } vec_t;

  typedef struct {
    int          cyc;
    int          idx;
    logic [16:0] exp;
  } sb_t;

  vec_t vecs[22];
  sb_t  sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare registered outputs in the cycle an expectation is due
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      sb_t e;
      e = sb.pop_front();
      check($sformatf("vec%0d", e.idx),
            {15'd0, regWrite, branchEnable, LUTIndex, Aluop, shiftDirection, shiftAmount,
             memWrite, memRead, mem_req},
            {15'd0, e.exp});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; instr = '0; instr_valid = 1'b0; equal = 1'b0; lessThan = 1'b0;
    mem_ack = 1'b0; start = 1'b0;

    //            instr         v  eq lt rw br lut       alu     sd sa
    vecs[0]  = '{9'b00_011_0011, 1, 0, 0, 1, 0, 5'b00000, 3'b011, 0, 3'd0}; // ADD
    vecs[1]  = '{9'b00_000_0000, 0, 0, 0, 0, 0, 5'b00000, 3'b000, 0, 3'd0}; // bubble
    vecs[2]  = '{9'b00_000_0111, 1, 1, 0, 0, 0, 5'b00000, 3'b000, 0, 3'd0}; // EQ eq=1
    vecs[3]  = '{9'b10_00_10110, 1, 0, 0, 0, 1, 5'b10110, 3'b000, 0, 3'd0}; // BEQ
    vecs[4]  = '{9'b10_01_00011, 1, 0, 0, 0, 0, 5'b00011, 3'b000, 0, 3'd0}; // BLT
    vecs[5]  = '{9'b10_10_11111, 1, 0, 0, 0, 1, 5'b11111, 3'b000, 0, 3'd0}; // BLTE
    vecs[6]  = '{9'b00_010_0111, 1, 0, 0, 0, 0, 5'b00000, 3'b010, 0, 3'd0}; // EQ eq=0
    vecs[7]  = '{9'b10_00_00101, 1, 1, 1, 0, 0, 5'b00101, 3'b000, 0, 3'd0}; // BEQ
    vecs[8]  = '{9'b00_100_0101, 1, 0, 1, 0, 0, 5'b00000, 3'b100, 0, 3'd0}; // SLT lt=1
    vecs[9]  = '{9'b10_01_01010, 1, 0, 0, 0, 1, 5'b01010, 3'b000, 0, 3'd0}; // BLT
    vecs[10] = '{9'b10_11_00000, 1, 0, 0, 0, 1, 5'b00000, 3'b000, 0, 3'd0}; // BUN
    vecs[11] = '{9'b11_11_00000, 1, 0, 0, 0, 1, 5'b00000, 3'b000, 0, 3'd0}; // BB
    vecs[12] = '{9'b11_10_00000, 1, 0, 0, 0, 0, 5'b00000, 3'b000, 0, 3'd0}; // BF
    vecs[13] = '{9'b11_01_00101, 1, 0, 0, 1, 0, 5'b00000, 3'b000, 1, 3'd5}; // LSR 5
    vecs[14] = '{9'b11_00_00011, 1, 0, 0, 1, 0, 5'b00000, 3'b000, 0, 3'd3}; // LSL 3
    vecs[15] = '{9'b00_111_1001, 1, 1, 0, 0, 0, 5'b00000, 3'b111, 0, 3'd0}; // R NOP
    vecs[16] = '{9'b01_010_0000, 1, 0, 0, 0, 0, 5'b00000, 3'b000, 0, 3'd0}; // M NOP
    vecs[17] = '{9'b10_00_00001, 1, 0, 0, 0, 0, 5'b00001, 3'b000, 0, 3'd0}; // BEQ
    vecs[18] = '{9'b00_001_0100, 1, 0, 0, 1, 0, 5'b00000, 3'b001, 0, 3'd0}; // SUB
    vecs[19] = '{9'b00_110_0110, 1, 1, 1, 0, 0, 5'b00000, 3'b110, 0, 3'd0}; // SLTE
    vecs[20] = '{9'b10_10_00001, 1, 0, 0, 0, 1, 5'b00001, 3'b000, 0, 3'd0}; // BLTE
    vecs[21] = '{9'b10_11_00111, 0, 0, 0, 0, 0, 5'b00000, 3'b000, 0, 3'd0}; // invalid

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {regWrite, memWrite, memRead, branchEnable, mem_req, LUTIndex,
                            Aluop, shiftDirection, shiftAmount, done, error}, 0);
    check("reset_ready", instr_ready, 0);

    // Release; one IDLE cycle, then EXEC
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", instr_ready, 0);
    tick();
    check("exec_ready", instr_ready, 1);

    // Vector table, back-to-back from the first acceptable cycle
    for (int i = 0; i < 22; i++) begin
      instr = vecs[i].instr; instr_valid = vecs[i].valid;
      equal = vecs[i].eq;    lessThan = vecs[i].lt;
      sb.push_back('{cyc + 1, i, {vecs[i].rw, vecs[i].br, vecs[i].lut, vecs[i].alu,
                                  vecs[i].sd, vecs[i].sa, 3'b000}});
      tick();
    end
    instr_valid = 1'b0; equal = 1'b0; lessThan = 1'b0;
    tick();
    check("sb_drained", sb.size(), 0);

    // Load with ack on the third wait cycle
    instr = 9'b01_001_0000; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) mem_ack = 1'b1;
      @(negedge clk);
      check($sformatf("load_wait%0d", k), {mem_req, memRead, memWrite, instr_ready}, 4'b1100);
      tick();
    end
    mem_ack = 1'b0;
    @(negedge clk);
    check("load_ack", {mem_req, memRead, regWrite, instr_ready}, 4'b0011);
    tick();
    @(negedge clk);
    check("load_rw_pulse", regWrite, 0);
    tick();

    // Store with no ack runs into the timeout
    instr = 9'b01_000_0000; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      check($sformatf("store_wait%0d", k), {mem_req, memWrite, error, done}, 4'b1100);
      tick();
    end
    @(negedge clk);
    check("timeout", {error, done, mem_req, memWrite, instr_ready}, 5'b11000);
    tick();
    instr = 9'b00_011_0011; instr_valid = 1'b1;  // not accepted while halted
    tick();
    instr_valid = 1'b0;
    @(negedge clk);
    check("halted_ignores", {regWrite, Aluop, done, error}, 6'b0_000_11);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("restart", {instr_ready, error, done}, 3'b100);
    tick();

    // HALT instruction, then start
    instr = 9'b01_111_0000; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    @(negedge clk);
    check("halt", {done, error, instr_ready}, 3'b100);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("halt_restart", {done, instr_ready}, 2'b01);
    tick();

    // Reset during MEM_WAIT drops mem_req immediately
    instr = 9'b01_001_0000; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_req", mem_req, 1);
    #1 rst_n = 1'b0;
    #1 check("async_reset_req", {mem_req, memRead}, 2'b00);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", instr_ready, 0);
    tick();
    @(negedge clk);
    check("post_reset_exec", instr_ready, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
# control_fsm

Registered, handshaked successor to the combinational instruction decoder. It accepts one instruction per cycle from fetch and decodes the four instruction classes (R/M/B/S) into registered control pulses. Compare flags live in an internal flag register, and memory operations are sequenced through a request/acknowledge handshake with timeout. A HALT instruction parks the block until restarted. It sits between fetch and the datapath/data-memory port.

## Interface
- INSTR_W, 9, instruction width; must equal LUT_W+4
- LUT_W, 5, branch LUT index width (instr[LUT_W-1:0])
- SHAMT_W, 3, shift amount width (instr[SHAMT_W-1:0]); SHAMT_W <= LUT_W
- MEM_TIMEOUT, 15, max cycles waiting for mem_ack; 0 disables timeout

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr  in  INSTR_W  instruction word
- instr_valid  in  1  instr is valid
- instr_ready  out  1  block accepts instr this cycle; combinational, =1 only in EXEC
- equal, lessThan  in  1 each  ALU compare results for the instruction presented this cycle
- mem_ack  in  1  data memory completed the request
- start  in  1  leave HALTED
- regWrite, memWrite, memRead, branchEnable  out  1 each  registered control
- mem_req  out  1  memory request, held until ack or timeout
- LUTIndex  out  LUT_W;  Aluop  out  3;  shiftDirection  out  1 (1=right);  shiftAmount  out  SHAMT_W
- done  out  1  in HALTED;  error  out  1  sticky timeout flag

## Operation
- Fields: type=instr[INSTR_W-1 -: 2] (R=00, M=01, B=10, S=11); op3=instr[INSTR_W-3 -: 3]; op2=top 2 bits of op3; func=instr[3:0].
- Accept = instr_valid && instr_ready. Outputs update on the edge after accept.
- R: Aluop=op3. func 0..4 (AND, OR, XOR, ADD, SUB) pulse regWrite. func 5..7 (SLT, SLTE, EQ) load flag_eq<=equal, flag_lt<=lessThan with no regWrite. func 8..15 are NOPs.
- M: op3=000 store (memWrite+mem_req, enter MEM_WAIT); 001 load (memRead+mem_req, enter MEM_WAIT); 111 HALT (enter HALTED); others NOP.
- B: LUTIndex=instr[LUT_W-1:0]. branchEnable uses the **registered** flags: 00 BEQ flag_eq; 01 BLT flag_lt; 10 BLTE flag_lt|flag_eq; 11 BUN always.
- S: 00 LSL and 01 LSR set shiftDirection (0/1), shiftAmount=instr[SHAMT_W-1:0] and pulse regWrite. 10 BF branches on flag_eq. 11 BB branches on flag_lt.
- States:
  - IDLE -> EXEC, unconditionally.
  - EXEC -> MEM_WAIT on a load or store.
  - EXEC -> HALTED on HALT.
  - MEM_WAIT -> EXEC on mem_ack.
  - MEM_WAIT -> HALTED on timeout; error<=1.
  - HALTED -> EXEC on start; done<=0, error<=0.
- start is ignored outside HALTED. Instructions are never accepted outside EXEC.

## Timing
- Reset (async) sets:
  - state=IDLE;
  - all outputs 0 (LUTIndex, Aluop, shiftAmount = 0);
  - flag_eq=flag_lt=0; wait counter=0.
- First accept is possible in the 2nd cycle after reset release.
- regWrite, branchEnable, shiftDirection/shiftAmount, Aluop and LUTIndex are valid for exactly one cycle after accept. They return to 0 afterwards unless a new accept occurs.
- Memory op accepted at cycle T:
  - T+1: mem_req=1 and memRead/memWrite=1, held while in MEM_WAIT.
  - mem_ack sampled at T+k: at T+k+1, mem_req and memRead/memWrite are 0, state=EXEC, and regWrite=1 for one cycle (loads only).
- Wait counter starts at 1 on the first MEM_WAIT cycle. If count reaches MEM_TIMEOUT with mem_ack=0, the next edge sets error=1, done=1, mem_req=0 and state=HALTED. If mem_ack arrives on the limit cycle, the ack wins.
- Back-to-back case: a compare accepted at T updates the flags at T+1, so a branch accepted at T+1 sees the new flags.
- done=1 from the cycle after the HALT/timeout edge until the cycle after start.
- Reset asserted mid-MEM_WAIT clears mem_req immediately (asynchronously).

## Structure
- Package control_pkg holds:
  - instruction_type enum;
  - state_t enum (IDLE, EXEC, MEM_WAIT, HALTED);
  - R func, M op, B/S condition constants.
- Sub-module instr_decode holds the pure-combinational field decode. It takes instr plus the flags and produces next control values. control_fsm registers these and owns the state, flags and counter.

## Test plan
- Reset, then ADD (R, Aluop=011, func=0011) valid at cycle 2 -> regWrite=1, Aluop=011 at cycle 3; 0 at cycle 4.
- EQ with equal=1, then BEQ next cycle -> branchEnable=1 one cycle after BEQ accept. Repeat with equal=0 -> branchEnable=0.
- Load, mem_ack on the 3rd wait cycle -> mem_req/memRead high 3 cycles; instr_ready=0 throughout; regWrite=1 the cycle after ack.
- Store, no mem_ack, MEM_TIMEOUT=15 -> after 15 wait cycles, error=1, done=1, mem_req=0, instr_ready=0; start -> EXEC, error=0.
- LSR with instr[2:0]=101 -> shiftDirection=1, shiftAmount=5, regWrite=1.
- rst_n low during MEM_WAIT -> mem_req=0 immediately; IDLE then EXEC after release.
